cs161_multicycle_control: RTL
=============================

Name: cs161_multicycle_control

Overview:
- Moore-style FSM that sequences a multi-cycle MIPS datapath in the cs161 processor.
- Per instruction it issues the following, one step per state:
  - PC/IR write strobes
  - memory strobes
  - register-file controls
  - ALU operand selects and alu_op
- Waits on a memory ready handshake, so instruction/data memory may take wait states.
- Counts retired instructions and halts sticky on unsupported opcodes.

Parameters:
CNT_WIDTH, 32, width of retired-instruction counter (wraps modulo 2^CNT_WIDTH)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-low reset
instr_op  input  6  opcode field from instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes current access this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load qualified by zero (beq)
pc_en  output  1  pc_write | (pc_write_cond & zero), combinational
i_or_d  output  1  memory address select: 0=PC, 1=ALUOut
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
ir_write  output  1  instruction register load
mem_to_reg  output  1  register write data: 0=ALUOut, 1=MDR
reg_dst  output  1  destination: 0=rt, 1=rd
reg_write  output  1  register file write enable
alu_src_a  output  1  0=PC, 1=reg A
alu_src_b  output  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  output  2  00=add, 01=sub, 10=use funct
pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target
state_dbg  output  4  current state encoding
illegal_op  output  1  sticky: unsupported opcode decoded
instr_retired  output  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset: rst=0 sampled at a clk edge sets:
  - state=FETCH
  - instr_retired=0
  - illegal_op=0
- While rst=0, all strobes are forced to 0 combinationally: pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write.
- Reset mid-access abandons the access; no retire count is recorded.
- Output defaults in every state: strobes 0; selects 0; alu_op=00; pc_source=00. Only the assignments listed below deviate.
- Supported opcodes:
  - R-type 0x00
  - lw 0x23
  - sw 0x2B
  - beq 0x04
  - j 0x02
  - addi 0x08
- FETCH(0):
  - Always drives mem_read=1, i_or_d=0, alu_src_b=01.
  - When mem_ready=1: ir_write=1 and pc_write=1 in that same cycle, then go to DECODE.
  - When mem_ready=0: ir_write=0, pc_write=0, stay in FETCH.
- DECODE(1): alu_src_b=11. Next state by opcode:
  - R-type -> R_EXEC
  - lw/sw -> MEM_ADDR
  - beq -> BRANCH
  - j -> JUMP
  - addi -> ADDI_EXEC
  - other -> HALT
- MEM_ADDR(2): alu_src_a=1, alu_src_b=10. Next: lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD(3): mem_read=1, i_or_d=1. Stays until mem_ready=1, then MEM_WB.
- MEM_WB(4): reg_write=1, mem_to_reg=1, reg_dst=0. Retire; go to FETCH.
- MEM_WR(5):
  - mem_write=1 and i_or_d=1, held until mem_ready=1.
  - On the mem_ready=1 cycle: retire, go to FETCH.
  - mem_write must not drop before mem_ready.
- R_EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=10. Go to R_WB.
- R_WB(7): reg_write=1, reg_dst=1. Retire; go to FETCH.
- BRANCH(8): alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01. Retire; go to FETCH.
- JUMP(9): pc_write=1, pc_source=10. Retire; go to FETCH.
- ADDI_EXEC(10): alu_src_a=1, alu_src_b=10. Go to ADDI_WB.
- ADDI_WB(11): reg_write=1, reg_dst=0. Retire; go to FETCH.
- HALT(12):
  - All strobes 0; illegal_op=1.
  - Remains in HALT until reset.
- Unused encodings 13-15 go to HALT on the next edge.
- Retire: instr_retired increments by 1 on the edge leaving a final state. Wraps at all-ones to 0.
- mem_ready is ignored outside FETCH/MEM_RD/MEM_WR.
- Latency with mem_ready tied 1, in cycles per instruction:
  - beq 3, j 3
  - R 4, addi 4, sw 4
  - lw 5
  - Each wait cycle adds 1 in its memory state.

Decomposition:
- Package cs161_ctrl_pkg holds:
  - state encodings (4-bit)
  - opcode constants
  - alu_op, alu_src_b and pc_source encodings
  - STATE_W
- One sub-module: cs161_ctrl_outputs, a purely combinational state -> control-vector decode including the rst gating.
- The parent holds the state register, next-state logic, counter and illegal flag.

Test Plan:
- Reset and first fetch:
  - Stimulus: rst=0 for 2 cycles, then 1; mem_ready=1; instr_op=0x00.
  - Response: during reset, all strobes=0. After release: state_dbg sequence 0,1,6,7,0; reg_write=1 only in state 7; instr_retired=1.
- lw with wait states:
  - Stimulus: instr_op=0x23; mem_ready low 2 cycles in FETCH and 3 in MEM_RD.
  - Response:
    - 10 cycles FETCH->FETCH.
    - mem_read held high through the waits; ir_write a single pulse.
    - mem_to_reg=1 and reg_write=1 only in MEM_WB.
- beq taken vs not:
  - Stimulus: instr_op=0x04 with zero=1, then with zero=0.
  - Response: pc_en=1 in BRANCH only when zero=1; each takes 3 cycles; count +2.
- sw handshake:
  - Stimulus: instr_op=0x2B, mem_ready=0 for 4 cycles in MEM_WR.
  - Response: mem_write stays 1 for 5 cycles; reg_write never 1.
- Illegal opcode:
  - Stimulus: instr_op=0x3F.
  - Response: DECODE->HALT; illegal_op=1 and stays; no strobes for 20 cycles; rst=0 clears to FETCH.
- Counter wrap and mid-op reset:
  - Stimulus: CNT_WIDTH=4; 16 j instructions; then rst=0 asserted in MEM_RD.
  - Response: count wraps 15->0. The reset drops mem_read the same cycle; the next edge gives state 0 and count 0.

Source files
------------

// File: rtl/cs161_ctrl_pkg.sv
// Shared constants and control bundle for the cs161 multicycle controller.
// Holds state/opcode encodings, mux select codes and the final-state helper.
package cs161_ctrl_pkg;

   localparam int STATE_W = 4;

   localparam logic [3:0] S_FETCH     = 4'd0;
   localparam logic [3:0] S_DECODE    = 4'd1;
   localparam logic [3:0] S_MEM_ADDR  = 4'd2;
   localparam logic [3:0] S_MEM_RD    = 4'd3;
   localparam logic [3:0] S_MEM_WB    = 4'd4;
   localparam logic [3:0] S_MEM_WR    = 4'd5;
   localparam logic [3:0] S_R_EXEC    = 4'd6;
   localparam logic [3:0] S_R_WB      = 4'd7;
   localparam logic [3:0] S_BRANCH    = 4'd8;
   localparam logic [3:0] S_JUMP      = 4'd9;
   localparam logic [3:0] S_ADDI_EXEC = 4'd10;
   localparam logic [3:0] S_ADDI_WB   = 4'd11;
   localparam logic [3:0] S_HALT      = 4'd12;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

   // True when the edge leaving this state completes an instruction.
   // A store only completes once memory accepts it.
   function automatic logic is_final(
      input logic [STATE_W-1:0] state,
      input logic               mem_ready
   );
      logic fin;
      fin = 1'b0;
      case (state)
         S_MEM_WB,
         S_R_WB,
         S_BRANCH,
         S_JUMP,
         S_ADDI_WB: fin = 1'b1;
         S_MEM_WR:  fin = mem_ready;
         default:   fin = 1'b0;
      endcase
      return fin;
   endfunction

endpackage

// File: rtl/cs161_ctrl_outputs.sv
// Combinational state -> control vector decode for the multicycle controller.
// Ports: rst (active-low, gates strobes), state, mem_ready -> ctrl bundle.
module cs161_ctrl_outputs
   import cs161_ctrl_pkg::*;
(
   input  logic               rst,
   input  logic [STATE_W-1:0] state,
   input  logic               mem_ready,
   output ctrl_t              ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            // IR and PC load only on the cycle the fetch completes.
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b = SRCB_IMM_SH;
         end
         S_MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEM_RD: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
         end
         S_R_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALU_FUNCT;
         end
         S_R_WB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_op        = ALU_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
         end
         S_ADDI_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_ADDI_WB: begin
            ctrl.reg_write = 1'b1;
         end
         default: ;
      endcase

      // Reset kills any in-flight access immediately.
      if (!rst) begin
         ctrl.pc_write      = 1'b0;
         ctrl.pc_write_cond = 1'b0;
         ctrl.mem_read      = 1'b0;
         ctrl.mem_write     = 1'b0;
         ctrl.ir_write      = 1'b0;
         ctrl.reg_write     = 1'b0;
      end
   end

endmodule

// File: rtl/cs161_multicycle_control.sv
// Multicycle MIPS control FSM: state register, next-state, retire counter, halt flag.
// Ports: clk, rst (sync active-low), instr_op, zero, mem_ready -> datapath controls.
module cs161_multicycle_control
   import cs161_ctrl_pkg::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [5:0]           instr_op,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 pc_write,
   output logic                 pc_write_cond,
   output logic                 pc_en,
   output logic                 i_or_d,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 ir_write,
   output logic                 mem_to_reg,
   output logic                 reg_dst,
   output logic                 reg_write,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           alu_op,
   output logic [1:0]           pc_source,
   output logic [3:0]           state_dbg,
   output logic                 illegal_op,
   output logic [CNT_WIDTH-1:0] instr_retired
);

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] state_next;
   ctrl_t              ctrl;

   always_comb begin
      state_next = state;
      case (state)
         S_FETCH:
            if (mem_ready) state_next = S_DECODE;
         S_DECODE: begin
            case (instr_op)
               OP_RTYPE: state_next = S_R_EXEC;
               OP_LW,
               OP_SW:    state_next = S_MEM_ADDR;
               OP_BEQ:   state_next = S_BRANCH;
               OP_J:     state_next = S_JUMP;
               OP_ADDI:  state_next = S_ADDI_EXEC;
               default:  state_next = S_HALT;
            endcase
         end
         S_MEM_ADDR:
            state_next = (instr_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:
            if (mem_ready) state_next = S_MEM_WB;
         S_MEM_WR:
            if (mem_ready) state_next = S_FETCH;
         S_R_EXEC:    state_next = S_R_WB;
         S_ADDI_EXEC: state_next = S_ADDI_WB;
         S_MEM_WB,
         S_R_WB,
         S_BRANCH,
         S_JUMP,
         S_ADDI_WB:   state_next = S_FETCH;
         S_HALT:      state_next = S_HALT;
         default:     state_next = S_HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= S_FETCH;
         instr_retired <= '0;
         illegal_op    <= 1'b0;
      end else begin
         state <= state_next;
         if (is_final(state, mem_ready))
            instr_retired <= instr_retired + CNT_WIDTH'(1);
         // Raised together with entry to HALT; HALT never exits.
         if (state_next == S_HALT)
            illegal_op <= 1'b1;
      end
   end

   cs161_ctrl_outputs u_outputs (
      .rst       (rst),
      .state     (state),
      .mem_ready (mem_ready),
      .ctrl      (ctrl)
   );

   assign pc_write      = ctrl.pc_write;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign pc_en         = ctrl.pc_write | (ctrl.pc_write_cond & zero);
   assign i_or_d        = ctrl.i_or_d;
   assign mem_read      = ctrl.mem_read;
   assign mem_write     = ctrl.mem_write;
   assign ir_write      = ctrl.ir_write;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign reg_dst       = ctrl.reg_dst;
   assign reg_write     = ctrl.reg_write;
   assign alu_src_a     = ctrl.alu_src_a;
   assign alu_src_b     = ctrl.alu_src_b;
   assign alu_op        = ctrl.alu_op;
   assign pc_source     = ctrl.pc_source;
   assign state_dbg     = state;

endmodule
